fu_issue_scheduler: RTL and testbench
=====================================

FU_ISSUE_SCHEDULER -- requirements
Module: fu_issue_scheduler

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, entries per FU-class queue (power of 2, >= 4).
REQ-002 Parameter: ISSUE_WIDTH, default 3, packets accepted per cycle; also the stall threshold.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 squash  input  1  pipeline flush; discards all queued packets.
REQ-006 rsb_issue_packets  input  RS_S_PACKET[2:0]  issued packets from RS; [2] oldest, [0] youngest.
REQ-007 fu_ready  input  4  per-class FU accept: [0]ALU_1, [1]LS_1, [2]MULT_1, [3]BRANCH.
REQ-008 fu_fifo_stall  output  FU_FIFO_PACKET  per-class stall (.alu/.ls/.mult/.branch) back to RS.
REQ-009 fu_pkt  output  RS_S_PACKET[3:0]  head packet per class, same index map as fu_ready.
REQ-010 fu_pkt_valid  output  4  head packet valid per class.

Function
REQ-011 Block SHALL hold four independent circular FIFOs, one per class, each with head pointer, tail pointer, count (width clog2(FIFO_DEPTH)+1).
REQ-012 A packet SHALL be enqueued iff .valid=1 and dec_fu_unit_sel is ALU_1, LS_1, MULT_1 or BRANCH; all other packets are dropped silently.
REQ-013 Multiple packets to one class in a cycle SHALL enqueue in order [2],[1],[0] at consecutive tail slots.
REQ-014 Per class, up to 3 enqueues and 1 dequeue SHALL occur per cycle; count_next = count + enq - deq.
REQ-015 fu_pkt_valid[c] SHALL equal (count_c != 0); fu_pkt[c] SHALL be the entry at head_c (show-ahead); fu_pkt[c] SHALL be all-zero when count_c = 0.
REQ-016 Dequeue on class c SHALL occur iff fu_pkt_valid[c] & fu_ready[c]; head advances by 1 at that posedge.
REQ-017 No bypass: an enqueued packet SHALL appear on fu_pkt no earlier than the cycle after enqueue (1-cycle minimum latency).
REQ-018 Pointers SHALL wrap modulo FIFO_DEPTH; entry order SHALL be preserved across wrap.
REQ-019 fu_fifo_stall.c SHALL be combinational from registered count: 1 iff (FIFO_DEPTH - count_c) < ISSUE_WIDTH; independent of this cycle's dequeue and inputs.
REQ-020 Enqueue attempts beyond free space (RS contract violation) SHALL be dropped per packet, youngest first; existing entries never overwritten; simulation assertion fires.
REQ-021 Dequeue on an empty class SHALL not occur regardless of fu_ready.
REQ-022 squash=1 SHALL, at the next posedge, set all heads, tails, counts to 0, ignoring that cycle's enqueues and dequeues; fu_pkt_valid still reflects pre-squash state during the squash cycle.
REQ-023 Classes SHALL be fully independent: stall, full or empty on one class never blocks another.

Reset
REQ-024 rst=1 SHALL at the posedge clear all pointers and counts; rst has priority over squash, enqueue and dequeue.
REQ-025 After reset: fu_pkt_valid=4'b0, fu_pkt all-zero, fu_fifo_stall all 0.
REQ-026 Reset mid-operation SHALL discard all queued packets; storage contents need not be cleared.

Verification
REQ-027 Post-reset, three valid ALU_1 packets (PC 0x10,0x14,0x18 on [2],[1],[0]), fu_ready=0 -> next cycle fu_pkt_valid[0]=1, fu_pkt[0].PC=0x10, count_alu=3, no stalls (DEPTH 8).
REQ-028 Fill ALU to 6 entries, fu_ready[0]=0 -> fu_fifo_stall.alu=1, other stall bits 0; one dequeue -> count 5, stall.alu=0 next cycle.
REQ-029 Mixed cycle: [2]=MULT_1, [1]=invalid, [0]=LS_1, all fu_ready=1 -> next cycle valid[2]=1, valid[1]=1, valid[0]=0; following cycle both dequeued, valid=4'b0.
REQ-030 Wrap: stream 20 BRANCH packets one per cycle with fu_ready[3] toggling -> output PC sequence identical to input order, no loss, count never >8.
REQ-031 Queue 5 ALU + 2 LS, assert squash with 3 new valid packets and fu_ready=4'hF -> next cycle all fu_pkt_valid=0, all counts 0, new packets not enqueued.
REQ-032 Assert rst with all four queues non-empty and stalls high -> next cycle fu_pkt_valid=4'b0 and all stall bits 0.

Source files
------------

// File: rtl/fu_issue_scheduler_if.sv
// Packet types and the RS <-> FU-queue bundle for the issue scheduler.
package fu_issue_scheduler_pkg;

   typedef enum logic [2:0] {
      FU_NONE = 3'd0,
      ALU_1   = 3'd1,
      LS_1    = 3'd2,
      MULT_1  = 3'd3,
      BRANCH  = 3'd4,
      FP_1    = 3'd5
   } fu_sel_e;

   typedef struct packed {
      logic        valid;
      fu_sel_e     dec_fu_unit_sel;
      logic [31:0] PC;
      logic [4:0]  dest_reg;
   } RS_S_PACKET;

   typedef struct packed {
      logic alu;
      logic ls;
      logic mult;
      logic branch;
   } FU_FIFO_PACKET;

endpackage

interface fu_issue_scheduler_if;
   import fu_issue_scheduler_pkg::*;

   logic                squash;
   RS_S_PACKET [2:0]    rsb_issue_packets;
   logic [3:0]          fu_ready;
   FU_FIFO_PACKET       fu_fifo_stall;
   RS_S_PACKET [3:0]    fu_pkt;
   logic [3:0]          fu_pkt_valid;

   // RS side / FU side driver
   modport master (
      output squash, rsb_issue_packets, fu_ready,
      input  fu_fifo_stall, fu_pkt, fu_pkt_valid
   );

   // Scheduler side
   modport slave (
      input  squash, rsb_issue_packets, fu_ready,
      output fu_fifo_stall, fu_pkt, fu_pkt_valid
   );

endinterface

// File: rtl/fu_issue_scheduler.sv
// Four per-class issue FIFOs (ALU, LS, MULT, BRANCH) between RS and the FUs.
// Class index map everywhere: 0=ALU_1, 1=LS_1, 2=MULT_1, 3=BRANCH.
module fu_issue_scheduler
   import fu_issue_scheduler_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned ISSUE_WIDTH = 3
) (
   input logic                clk,
   input logic                rst,
   fu_issue_scheduler_if.slave bus
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;

   RS_S_PACKET mem_q [4][FIFO_DEPTH];
   ptr_t       head_q  [4];
   ptr_t       tail_q  [4];
   cnt_t       count_q [4];

   logic [3:0][2:0] wr_en;
   ptr_t            wr_idx [4][3];
   cnt_t            enq    [4];
   logic [3:0]      deq;
   logic [3:0]      stall;
   logic            drop;

   // {hit, class index}; hit=0 for packets that belong to no queue
   function automatic logic [2:0] class_of(input fu_sel_e sel);
      case (sel)
         ALU_1:   class_of = 3'b100;
         LS_1:    class_of = 3'b101;
         MULT_1:  class_of = 3'b110;
         BRANCH:  class_of = 3'b111;
         default: class_of = 3'b000;
      endcase
   endfunction

   // Enqueue slot allocation: oldest lane first, so overflow drops youngest first
   always_comb begin
      wr_en = '0;
      drop  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         enq[c] = '0;
         for (int i = 0; i < 3; i++) wr_idx[c][i] = '0;
      end
      for (int c = 0; c < 4; c++) begin
         for (int i = 2; i >= 0; i--) begin
            if (bus.rsb_issue_packets[i].valid &&
                class_of(bus.rsb_issue_packets[i].dec_fu_unit_sel) == {1'b1, 2'(c)}) begin
               if (count_q[c] + enq[c] < cnt_t'(FIFO_DEPTH)) begin
                  wr_en[c][i]  = 1'b1;
                  wr_idx[c][i] = tail_q[c] + ptr_t'(enq[c]);
                  enq[c]       = enq[c] + cnt_t'(1);
               end else begin
                  drop = 1'b1;
               end
            end
         end
      end
   end

   // Show-ahead outputs, dequeue decision and stall, all from registered counts
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         bus.fu_pkt_valid[c] = (count_q[c] != '0);
         bus.fu_pkt[c]       = (count_q[c] != '0) ? mem_q[c][head_q[c]] : '0;
         deq[c]              = (count_q[c] != '0) && bus.fu_ready[c];
         stall[c]            = (cnt_t'(FIFO_DEPTH) - count_q[c]) < cnt_t'(ISSUE_WIDTH);
      end
      bus.fu_fifo_stall.alu    = stall[0];
      bus.fu_fifo_stall.ls     = stall[1];
      bus.fu_fifo_stall.mult   = stall[2];
      bus.fu_fifo_stall.branch = stall[3];
   end

   // Pointer/count state; rst beats squash beats normal traffic
   always_ff @(posedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (rst || bus.squash) begin
            head_q[c]  <= '0;
            tail_q[c]  <= '0;
            count_q[c] <= '0;
         end else begin
            head_q[c]  <= head_q[c] + ptr_t'(deq[c]);
            tail_q[c]  <= tail_q[c] + ptr_t'(enq[c]);
            count_q[c] <= count_q[c] + enq[c] - cnt_t'(deq[c]);
         end
      end
   end

   // Storage writes; contents are don't-care once counts are cleared
   always_ff @(posedge clk) begin
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (wr_en[c][i]) mem_q[c][wr_idx[c][i]] <= bus.rsb_issue_packets[i];
         end
      end
   end

   // RS must honour stall; a dropped packet means the contract was broken
   always_ff @(posedge clk) begin
      if (!rst && !bus.squash) begin
         assert (!drop) else $error("fu_issue_scheduler: enqueue dropped on full queue");
      end
   end

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler (FIFO_DEPTH=8, ISSUE_WIDTH=3).
module tb_fu_issue_scheduler;
   import fu_issue_scheduler_pkg::*;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   fu_issue_scheduler_if bus ();

   fu_issue_scheduler #(.FIFO_DEPTH(8), .ISSUE_WIDTH(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      RS_S_PACKET [2:0] pkts;
      logic [3:0]       ready;
      logic [3:0]       exp_valid;
      logic [3:0]       exp_stall;
      logic [31:0]      exp_pc [4];
   } vec_t;

   vec_t tbl [7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic RS_S_PACKET mk(input fu_sel_e s, input logic [31:0] pc);
      RS_S_PACKET p;
      p                 = '0;
      p.valid           = 1'b1;
      p.dec_fu_unit_sel = s;
      p.PC              = pc;
      p.dest_reg        = pc[6:2];
      return p;
   endfunction

   function automatic logic [3:0] stall_bits();
      return {bus.fu_fifo_stall.branch, bus.fu_fifo_stall.mult,
              bus.fu_fifo_stall.ls, bus.fu_fifo_stall.alu};
   endfunction

   task automatic idle_inputs();
      bus.squash            = 1'b0;
      bus.rsb_issue_packets = '0;
      bus.fu_ready          = 4'b0;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, 64'(bus.fu_pkt_valid), 64'h0);
      chk({tag, "_stall"}, 64'(stall_bits()), 64'h0);
      for (int c = 0; c < 4; c++) chk({tag, "_pkt_zero"}, 64'(bus.fu_pkt[c]), 64'h0);
   endtask

   initial begin
      RS_S_PACKET  p;
      logic [31:0] q [$];
      int          mcnt;
      int          sent;
      int          cyc;
      logic        send;

      n_total = 0;
      n_pass  = 0;

      // Stimulus table: one cycle each, expectations sampled after the edge
      foreach (tbl[k]) begin
         tbl[k].pkts = '0;
         for (int c = 0; c < 4; c++) tbl[k].exp_pc[c] = 32'h0;
      end
      tbl[0].pkts[2] = mk(ALU_1, 32'h10);
      tbl[0].pkts[1] = mk(ALU_1, 32'h14);
      tbl[0].pkts[0] = mk(ALU_1, 32'h18);
      tbl[0].ready = 4'b0000; tbl[0].exp_valid = 4'b0001; tbl[0].exp_stall = 4'b0000;
      tbl[0].exp_pc[0] = 32'h10;
      tbl[1].pkts[2] = mk(ALU_1, 32'h1C);
      tbl[1].pkts[1] = mk(ALU_1, 32'h20);
      tbl[1].pkts[0] = mk(ALU_1, 32'h24);
      tbl[1].ready = 4'b0000; tbl[1].exp_valid = 4'b0001; tbl[1].exp_stall = 4'b0001;
      tbl[1].exp_pc[0] = 32'h10;
      tbl[2].ready = 4'b0001; tbl[2].exp_valid = 4'b0001; tbl[2].exp_stall = 4'b0000;
      tbl[2].exp_pc[0] = 32'h14;
      tbl[3].pkts[2] = mk(MULT_1, 32'h100);
      p = mk(ALU_1, 32'h200); p.valid = 1'b0;
      tbl[3].pkts[1] = p;
      tbl[3].pkts[0] = mk(LS_1, 32'h300);
      tbl[3].ready = 4'b1111; tbl[3].exp_valid = 4'b0111; tbl[3].exp_stall = 4'b0000;
      tbl[3].exp_pc[0] = 32'h18; tbl[3].exp_pc[1] = 32'h300; tbl[3].exp_pc[2] = 32'h100;
      tbl[4].ready = 4'b0110; tbl[4].exp_valid = 4'b0001; tbl[4].exp_stall = 4'b0000;
      tbl[4].exp_pc[0] = 32'h18;
      tbl[5].pkts[2] = mk(FP_1, 32'h400);
      tbl[5].pkts[1] = mk(BRANCH, 32'h500);
      tbl[5].pkts[0] = mk(ALU_1, 32'h28);
      tbl[5].ready = 4'b0001; tbl[5].exp_valid = 4'b1001; tbl[5].exp_stall = 4'b0000;
      tbl[5].exp_pc[0] = 32'h1C; tbl[5].exp_pc[3] = 32'h500;
      tbl[6].ready = 4'b1000; tbl[6].exp_valid = 4'b0001; tbl[6].exp_stall = 4'b0000;
      tbl[6].exp_pc[0] = 32'h1C;

      // Reset
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk_empty("reset");

      foreach (tbl[k]) begin
         bus.rsb_issue_packets = tbl[k].pkts;
         bus.fu_ready          = tbl[k].ready;
         step();
         chk($sformatf("v%0d_valid", k), 64'(bus.fu_pkt_valid), 64'(tbl[k].exp_valid));
         chk($sformatf("v%0d_stall", k), 64'(stall_bits()), 64'(tbl[k].exp_stall));
         for (int c = 0; c < 4; c++) begin
            if (tbl[k].exp_valid[c])
               chk($sformatf("v%0d_pc%0d", k, c), 64'(bus.fu_pkt[c].PC), 64'(tbl[k].exp_pc[c]));
            else
               chk($sformatf("v%0d_zero%0d", k, c), 64'(bus.fu_pkt[c]), 64'h0);
         end
      end

      // Squash with 5 ALU + 2 LS queued and new valid packets on the bus
      bus.rsb_issue_packets[2] = mk(ALU_1, 32'h2C);
      bus.rsb_issue_packets[1] = mk(LS_1, 32'h600);
      bus.rsb_issue_packets[0] = mk(LS_1, 32'h604);
      bus.fu_ready = 4'b0000;
      step();
      chk("presquash_valid", 64'(bus.fu_pkt_valid), 64'b0011);
      chk("presquash_ls_pc", 64'(bus.fu_pkt[1].PC), 64'h600);
      bus.squash = 1'b1;
      bus.rsb_issue_packets[2] = mk(MULT_1, 32'h700);
      bus.rsb_issue_packets[1] = mk(BRANCH, 32'h704);
      bus.rsb_issue_packets[0] = mk(ALU_1, 32'h708);
      bus.fu_ready = 4'hF;
      #2;
      chk("squash_cycle_valid", 64'(bus.fu_pkt_valid), 64'b0011);
      step();
      idle_inputs();
      chk_empty("squash");
      step();
      chk_empty("squash_noenq");

      // BRANCH stream across pointer wrap, RS honouring the stall threshold
      mcnt = 0;
      sent = 0;
      cyc  = 0;
      while (!(sent == 20 && mcnt == 0)) begin
         if (cyc >= 200) begin
            chk("wrap_timeout", 64'(cyc), 64'd0);
            break;
         end
         chk("wrap_stall", 64'(bus.fu_fifo_stall.branch), 64'((8 - mcnt) < 3));
         chk("wrap_valid", 64'(bus.fu_pkt_valid[3]), 64'(mcnt != 0));
         send = (sent < 20) && ((8 - mcnt) >= 3);
         bus.fu_ready = {cyc[0], 3'b000};
         bus.rsb_issue_packets = '0;
         if (send) bus.rsb_issue_packets[2] = mk(BRANCH, 32'h1000 + 32'(sent) * 4);
         if (cyc[0] && mcnt > 0) begin
            chk("wrap_pc", 64'(bus.fu_pkt[3].PC), 64'(q[0]));
            void'(q.pop_front());
            mcnt--;
         end
         if (send) begin
            q.push_back(32'h1000 + 32'(sent) * 4);
            mcnt++;
            sent++;
         end
         chk("wrap_cnt_le8", 64'(mcnt <= 8), 64'd1);
         step();
         cyc++;
      end
      idle_inputs();
      chk("wrap_drained", 64'(bus.fu_pkt_valid), 64'h0);

      // Fill every class to 6, then reset mid-operation
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
               bus.rsb_issue_packets[i] = mk(fu_sel_e'(c + 1), 32'h2000 + 32'(c * 16 + r * 4 + i));
            step();
         end
      end
      idle_inputs();
      chk("full_valid", 64'(bus.fu_pkt_valid), 64'hF);
      chk("full_stall", 64'(stall_bits()), 64'hF);
      chk("full_mult_pc", 64'(bus.fu_pkt[2].PC), 64'h2022);
      rst = 1'b1;
      bus.fu_ready = 4'hF;
      step();
      rst = 1'b0;
      idle_inputs();
      chk_empty("midrst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
